// File: rtl/raycast_seq.sv
// Frame-level sequencer for the per-column raycast core; stores each column depth for the pixel path.
// Optional double-buffered column store: define RAYCAST_SEQ_DBUF_EN.
`timescale 1ns/1ps
module raycast_seq #(
  parameter int unsigned NUM_COLS  = 320,
  parameter int unsigned MAX_STEPS = 64,
  parameter int unsigned COL_W     = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  output logic               init,
  output logic               mult,
  output logic               loop,
  output logic               ceil_calc,
  output logic [31:0]        col,
  input  logic               hitwall,
  input  logic [12:0]        depth,
  input  logic [COL_W-1:0]   rd_col,
  output logic [12:0]        rd_depth,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  output logic [15:0]        timeout_cnt
);

  localparam int unsigned STEP_W  = $clog2(MAX_STEPS + 1);
  localparam int unsigned DEPTH_W = 13;
  localparam int unsigned ADDR_W  = COL_W + 1;
`ifdef RAYCAST_SEQ_DBUF_EN
  localparam int unsigned BANKS = 2;
`else
  localparam int unsigned BANKS = 1;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_MULT, S_LOOP, S_SETTLE, S_CEIL, S_WAIT, S_STORE, S_NEXT
  } state_t;

  state_t              state_q, state_nxt;
  logic [COL_W-1:0]    col_q, col_nxt;
  logic [STEP_W-1:0]   step_q, step_nxt;
  logic                hit_arm_q, hit_arm_nxt;
  logic [15:0]         timeout_nxt;
  logic                overrun_nxt;
  logic                last_col, at_max, hit;

  assign last_col = (col_q == COL_W'(NUM_COLS - 1));
  assign at_max   = (step_q == STEP_W'(MAX_STEPS));
  assign hit      = hitwall && hit_arm_q;
  assign col      = 32'(col_q);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:   if (frame_start) state_nxt = S_INIT;
      S_INIT:   state_nxt = S_MULT;
      S_MULT:   state_nxt = S_LOOP;
      S_LOOP:   state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = (hit || at_max) ? S_CEIL : S_MULT;
      S_CEIL:   state_nxt = S_WAIT;
      S_WAIT:   state_nxt = S_STORE;
      S_STORE:  state_nxt = S_NEXT;
      S_NEXT:   state_nxt = (!last_col || frame_start) ? S_INIT : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    col_nxt     = col_q;
    step_nxt    = step_q;
    hit_arm_nxt = hit_arm_q;
    timeout_nxt = timeout_cnt;
    overrun_nxt = frame_start && (state_q != S_IDLE) && !((state_q == S_NEXT) && last_col);
    case (state_q)
      S_IDLE: if (frame_start) begin
        col_nxt     = '0;
        timeout_nxt = '0;
      end
      S_INIT: begin
        step_nxt    = '0;
        hit_arm_nxt = 1'b0;
      end
      // A stale hitwall still high at the first probe is accepted as a step-1 hit.
      S_MULT: if (!hitwall || (step_q == '0)) hit_arm_nxt = 1'b1;
      S_LOOP: step_nxt = step_q + STEP_W'(1);
      S_SETTLE: if (!hit && at_max && (timeout_cnt != 16'hFFFF))
        timeout_nxt = timeout_cnt + 16'd1;
      S_NEXT: begin
        if (!last_col) begin
          col_nxt = col_q + COL_W'(1);
        end else if (frame_start) begin
          col_nxt     = '0;
          timeout_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  // Registered strobes and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init        <= 1'b0;
      mult        <= 1'b0;
      loop        <= 1'b0;
      ceil_calc   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      col_q       <= '0;
      step_q      <= '0;
      hit_arm_q   <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      init        <= (state_nxt == S_INIT);
      mult        <= (state_nxt == S_MULT);
      loop        <= (state_nxt == S_LOOP);
      ceil_calc   <= (state_nxt == S_CEIL);
      busy        <= (state_nxt != S_IDLE);
      frame_done  <= (state_nxt == S_NEXT) && last_col;
      overrun     <= overrun_nxt;
      col_q       <= col_nxt;
      step_q      <= step_nxt;
      hit_arm_q   <= hit_arm_nxt;
      timeout_cnt <= timeout_nxt;
    end
  end

  logic [DEPTH_W-1:0] mem [BANKS*NUM_COLS];
  logic [ADDR_W-1:0]  wr_addr, rd_addr;
  logic               rd_in_range;

  assign rd_in_range = (rd_col < COL_W'(NUM_COLS));

`ifdef RAYCAST_SEQ_DBUF_EN
  logic front_q;

  // Reads use the front bank, stores fill the back bank; swap when a frame completes.
  assign wr_addr = ADDR_W'(col_q)  + (front_q ? ADDR_W'(0) : ADDR_W'(NUM_COLS));
  assign rd_addr = ADDR_W'(rd_col) + (front_q ? ADDR_W'(NUM_COLS) : ADDR_W'(0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        front_q <= 1'b0;
    else if (frame_done) front_q <= ~front_q;
  end
`else
  assign wr_addr = ADDR_W'(col_q);
  assign rd_addr = ADDR_W'(rd_col);
`endif

  // Column store, not reset
  always_ff @(posedge clk) begin
    if (state_q == S_STORE) mem[wr_addr] <= depth;
  end

  // Registered read port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         rd_depth <= '0;
    else if (rd_in_range) rd_depth <= mem[rd_addr];
    else                  rd_depth <= '0;
  end

endmodule

// File: tb/tb_raycast_seq.sv
// Directed self-checking bench for raycast_seq with a simple behavioural raycast core model.
`timescale 1ns/1ps
module tb_raycast_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        init, mult, loop, ceil_calc;
  logic [31:0] col;
  logic        hitwall;
  logic [12:0] depth;
  logic [8:0]  rd_col;
  logic [12:0] rd_depth;
  logic        busy, frame_done, overrun;
  logic [15:0] timeout_cnt;

  int tests = 0;
  int failures = 0;

  // core model configuration
  int hit_step   = 1;
  int never_col  = -1;
  int dbase      = 0;
  int const_depth = 0;
  int lcnt;

  // monitor state
  int viol = 0;
  int last_strobe = 0;
  bit in_col = 0;
  int cur_loops = 0;
  int loops [320];
  int fd_mon = 0;
  int ov_mon = 0;

  raycast_seq dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .init(init), .mult(mult), .loop(loop), .ceil_calc(ceil_calc),
    .col(col), .hitwall(hitwall), .depth(depth),
    .rd_col(rd_col), .rd_depth(rd_depth), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  function automatic int step_for(input int c);
    return (c == never_col) ? 0 : hit_step;
  endfunction

  function automatic logic [12:0] depth_for(input int c);
    if (const_depth != 0) return 13'(const_depth);
    if (c == never_col)   return 13'd4000;
    return 13'(c + dbase);
  endfunction

  // Core model: hitwall and depth registered on their strobes, hitwall not cleared by init
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hitwall <= 1'b0;
      depth   <= '0;
      lcnt    <= 0;
    end else begin
      if (init) lcnt <= 0;
      if (loop) begin
        lcnt    <= lcnt + 1;
        hitwall <= (step_for(int'(col)) != 0) && (lcnt + 1 == step_for(int'(col)));
      end
      if (ceil_calc) depth <= depth_for(int'(col));
    end
  end

  // Strobe protocol monitor
  always @(negedge clk) begin
    if (!reset_n) begin
      last_strobe = 0;
      in_col = 0;
    end else begin
      if (32'(init) + 32'(mult) + 32'(loop) + 32'(ceil_calc) > 1) viol++;
      if (mult && !in_col) viol++;
      if (init) begin
        if (!(last_strobe == 0 || last_strobe == 4)) viol++;
        last_strobe = 1; in_col = 1; cur_loops = 0;
      end
      if (mult) begin
        if (!(last_strobe == 1 || last_strobe == 3)) viol++;
        last_strobe = 2;
      end
      if (loop) begin
        if (last_strobe != 2) viol++;
        last_strobe = 3; cur_loops++;
      end
      if (ceil_calc) begin
        if (last_strobe != 3) viol++;
        last_strobe = 4; in_col = 0;
        if (col < 32'd320) loops[col] = cur_loops;
      end
      if (frame_done) fd_mon++;
      if (overrun) ov_mon++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(output int bc, output int fdc, output int fda);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    bc = 0; fdc = 0; fda = 0;
    for (int i = 0; i < 6000 && busy; i++) begin
      bc++;
      if (frame_done) begin fdc++; fda = bc; end
      tick();
    end
  endtask

  task automatic drain(output int fdc);
    fdc = 0;
    for (int i = 0; i < 6000 && busy; i++) begin
      if (frame_done) fdc++;
      tick();
    end
  endtask

  task automatic wait_col(input int c, input bit need_loop, output int waited);
    waited = 0;
    while (waited < 6000 && !(col == 32'(c) && (!need_loop || loop))) begin
      tick();
      waited++;
    end
  endtask

  task automatic read(input int c, output logic [12:0] v);
    rd_col = 9'(c);
    tick();
    v = rd_depth;
  endtask

  int bc, fdc, fda, w;
  logic [12:0] v;

  initial begin
    reset_n = 1'b0; frame_start = 1'b0; rd_col = '0;
    repeat (3) tick();
    check("rst_strobes", {init, mult, loop, ceil_calc}, 0);
    check("rst_status", {busy, frame_done, overrun}, 0);
    check("rst_col", col, 0);
    check("rst_rd_depth", rd_depth, 0);
    check("rst_timeout", timeout_cnt, 0);
    reset_n = 1'b1;
    tick();

    // Frame A: every column hits on step 1, depth = col
    run_frame(bc, fdc, fda);
    check("a_busy_cycles", bc, 2560);
    check("a_frame_done_cnt", fdc, 1);
    check("a_frame_done_pos", fda, 2560);
    check("a_timeout", timeout_cnt, 0);
    read(100, v); check("a_rd100", v, 100);
    read(319, v); check("a_rd319", v, 319);
    read(1, v);   check("a_rd1", v, 1);
    read(320, v); check("a_rd320_oob", v, 0);
    read(511, v); check("a_rd511_oob", v, 0);

    // Frame B: column 5 never hits, others hit at step 3
    hit_step = 3; never_col = 5; dbase = 1000;
    run_frame(bc, fdc, fda);
    check("b_busy_cycles", bc, 319 * 14 + 197);
    check("b_col5_loops", loops[5], 64);
    check("b_col6_loops", loops[6], 3);
    check("b_timeout", timeout_cnt, 1);
    read(5, v); check("b_rd5", v, 4000);
    read(6, v); check("b_rd6", v, 1006);
    read(0, v); check("b_rd0", v, 1000);

    // Frame C: frame_start while busy at column 150
    hit_step = 1; never_col = -1; dbase = 0; ov_mon = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("c_timeout_cleared", timeout_cnt, 0);
    wait_col(150, 1'b0, w);
    check("c_reach150", 32'(w < 6000), 1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("c_overrun", overrun, 1);
    check("c_col_kept", col, 150);
    tick();
    check("c_overrun_clear", overrun, 0);
    wait_col(151, 1'b0, w);
    check("c_to151_cycles", w, 6);
    drain(fdc);
    check("c_frame_done_cnt", fdc, 1);
    check("c_overrun_pulses", ov_mon, 1);

    // Frame D: frame_start coincident with frame_done restarts immediately
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    w = 0;
    while (w < 6000 && !frame_done) begin tick(); w++; end
    check("d_saw_done", 32'(frame_done), 1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("d_b2b_busy_init", {busy, init, overrun}, 3'b110);
    check("d_b2b_col", col, 0);
    drain(fdc);
    check("d_b2b_done", fdc, 1);

    // Frame E: async reset mid-LOOP at column 200
    fd_mon = 0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    wait_col(200, 1'b1, w);
    check("e_reach200_loop", 32'(w < 6000), 1);
    reset_n = 1'b0;
    #1;
    check("e_async_strobes", {init, mult, loop, ceil_calc, busy, frame_done}, 0);
    check("e_async_col", col, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("e_no_frame_done", fd_mon, 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("e_restart_init", {busy, init}, 2'b11);
    check("e_restart_col", col, 0);
    drain(fdc);

    // Frames F1/F2: constant depth 1 then 2; reads mid-sweep of F2
    const_depth = 1;
    run_frame(bc, fdc, fda);
    check("f1_done", fdc, 1);
    const_depth = 2;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    wait_col(200, 1'b0, w);
    read(100, v);
`ifdef RAYCAST_SEQ_DBUF_EN
    check("f2_mid_rd100_front", v, 1);
`else
    check("f2_mid_rd100_torn", v, 2);
`endif
    read(300, v); check("f2_mid_rd300", v, 1);
    read(0, v);
`ifdef RAYCAST_SEQ_DBUF_EN
    check("f2_mid_rd0_front", v, 1);
`else
    check("f2_mid_rd0_torn", v, 2);
`endif
    drain(fdc);
    read(0, v);   check("f2_end_rd0", v, 2);
    read(319, v); check("f2_end_rd319", v, 2);

    check("protocol_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
